// File: rtl/ins_mem_responder.sv
// Instruction-memory responder: returns mem[ins_address] a fixed READ_LAT cycles after accept.
// Optional one-entry last-instruction cache enabled with `define LAST_INS_CACHE_EN.
module ins_mem_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              finish,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] ins_address,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] ins_out,
    output logic              ins_valid,
    output logic              addr_err,
    output logic              busy
);

    localparam int unsigned   IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]    CNT_INIT = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                wr_ok;
    logic                rd_in_range;
    logic                rd_edge;
    logic [DATA_W-1:0]   rd_data;

    assign accept      = fetch_req && enable && !finish;
    assign wr_ok       = prog_we && ({1'b0, prog_addr} < DEPTH_X);
    assign rd_in_range = {1'b0, addr_q} < DEPTH_X;
    assign rd_edge     = (state_q == StWait) && (cnt_q == 4'd0);
    assign rd_data     = mem[addr_q[IDX_W-1:0]];
    assign busy        = (state_q != StIdle);

    // Unreset store; the FSM samples it with <= so a same-edge write is read-before-write.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

`ifdef LAST_INS_CACHE_EN
    logic              last_vld_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [DATA_W-1:0] last_data_q;
    logic              hit_q;
    logic              cache_hit;

    assign cache_hit = last_vld_q && (ins_address == last_addr_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            ins_out     <= '0;
            ins_valid   <= 1'b0;
            addr_err    <= 1'b0;
`ifdef LAST_INS_CACHE_EN
            last_vld_q  <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
            hit_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        addr_q  <= ins_address;
                        cnt_q   <= CNT_INIT;
                        state_q <= StWait;
`ifdef LAST_INS_CACHE_EN
                        // A hit goes straight to the read edge so ins_valid follows in one cycle.
                        hit_q <= cache_hit;
                        if (cache_hit) begin
                            cnt_q <= 4'd0;
                        end
`endif
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ins_valid <= 1'b1;
                        state_q   <= StResp;
`ifdef LAST_INS_CACHE_EN
                        if (hit_q) begin
                            ins_out  <= last_data_q;
                            addr_err <= 1'b0;
                        end else begin
                            ins_out  <= rd_in_range ? rd_data : '0;
                            addr_err <= !rd_in_range;
                            if (rd_in_range) begin
                                last_addr_q <= addr_q;
                                last_data_q <= rd_data;
                                last_vld_q  <= 1'b1;
                            end
                        end
`else
                        ins_out  <= rd_in_range ? rd_data : '0;
                        addr_err <= !rd_in_range;
`endif
                    end
                end
                StResp: begin
                    ins_valid <= 1'b0;
                    addr_err  <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
`ifdef LAST_INS_CACHE_EN
            // Also drop an entry being filled on this edge if the same word is rewritten.
            if (wr_ok && ((prog_addr == last_addr_q) || (rd_edge && (prog_addr == addr_q)))) begin
                last_vld_q <= 1'b0;
            end
`endif
        end
    end

`ifndef LAST_INS_CACHE_EN
    logic unused_rd_edge;
    assign unused_rd_edge = rd_edge;
`endif

endmodule

// File: tb/tb_ins_mem_responder.sv
// Directed self-checking bench for ins_mem_responder (READ_LAT=2, DEPTH=64).
module tb_ins_mem_responder;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       finish;
    logic       fetch_req;
    logic [7:0] ins_address;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] ins_out;
    logic       ins_valid;
    logic       addr_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef LAST_INS_CACHE_EN
    localparam int HitLat = 1;
`else
    localparam int HitLat = 2;
`endif

    ins_mem_responder #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .DEPTH   (64),
        .READ_LAT(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .finish     (finish),
        .fetch_req  (fetch_req),
        .ins_address(ins_address),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .ins_out    (ins_out),
        .ins_valid  (ins_valid),
        .addr_err   (addr_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        fetch_req = 1'b0;
        prog_we = 1'b0;
        enable = 1'b1;
        finish = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    // Accept on the first edge, then walk every cycle until back in IDLE.
    task automatic do_fetch(input string name, input logic [7:0] addr, input int lat,
                            input logic [7:0] exp_data, input logic exp_err);
        ins_address = addr;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        ins_address = ~addr;
        for (int i = 0; i <= lat + 1; i++) begin
            if (i > 0) step();
            n_cmp++;
            if ({ins_valid, busy, addr_err} !== {i == lat, i <= lat, (i == lat) && exp_err}) begin
                n_err++;
                $display("FAIL %s_ctl cyc%0d: valid/busy/err=%b want %b", name, i,
                         {ins_valid, busy, addr_err}, {i == lat, i <= lat, (i == lat) && exp_err});
            end
            if (i == lat) begin
                n_cmp++;
                if (ins_out !== exp_data) begin
                    n_err++;
                    $display("FAIL %s_data: ins_out=%h want %h", name, ins_out, exp_data);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        finish = 1'b0;
        fetch_req = 1'b0;
        ins_address = 8'h00;
        prog_we = 1'b0;
        prog_addr = 8'h00;
        prog_data = 8'h00;
        #2;
        n_cmp++;
        if ({ins_out, ins_valid, addr_err, busy} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {ins_out, ins_valid, addr_err, busy});
        end
        step();
        rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_basic();
        apply_reset();
        prog_write(8'd0, 8'h11);
        prog_write(8'd1, 8'h22);
        prog_write(8'd2, 8'h33);
        prog_write(8'd3, 8'h44);
        do_fetch("basic", 8'd0, 2, 8'h11, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tab [3];
        exp_tab = '{8'h22, 8'h33, 8'h44};
        apply_reset();
        ins_address = 8'd1;
        fetch_req = 1'b1;
        // Accepts land on cycles 0, 4, 8; responses two edges later.
        for (int c = 0; c < 12; c++) begin
            step();
            n_cmp++;
            if (ins_valid !== (c % 4 == 2)) begin
                n_err++;
                $display("FAIL b2b_valid cyc%0d: got %b want %b", c, ins_valid, c % 4 == 2);
            end
            if (c % 4 == 2) begin
                n_cmp++;
                if (ins_out !== exp_tab[c / 4]) begin
                    n_err++;
                    $display("FAIL b2b_data cyc%0d: got %h want %h", c, ins_out, exp_tab[c / 4]);
                end
                ins_address = ins_address + 8'd1;
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_gating();
        apply_reset();
        finish = 1'b1;
        fetch_req = 1'b1;
        ins_address = 8'd0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                finish = 1'b0;
                enable = 1'b0;
            end
            step();
            n_cmp++;
            if ({busy, ins_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL gate_idle cyc%0d: busy/valid=%b want 00", i, {busy, ins_valid});
            end
        end
        enable = 1'b1;
        ins_address = 8'd3;
        step();
        fetch_req = 1'b0;
        finish = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ins_valid, ins_out} !== {1'b1, 8'h44}) begin
            n_err++;
            $display("FAIL gate_inflight: valid/data=%b/%h want 1/44", ins_valid, ins_out);
        end
        finish = 1'b0;
        step();
    endtask

    task automatic test_out_of_range();
        apply_reset();
        prog_write(8'd6, 8'h66);
        prog_write(8'd70, 8'hEE);
        do_fetch("oor_store", 8'd6, 2, 8'h66, 1'b0);
        do_fetch("oor_fetch", 8'd70, 2, 8'h00, 1'b1);
    endtask

    task automatic test_reset_abort();
        apply_reset();
        do_fetch("abort_pre", 8'd3, 2, 8'h44, 1'b0);
        ins_address = 8'd1;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ins_out, ins_valid, addr_err, busy} !== 11'b0) begin
            n_err++;
            $display("FAIL abort_outputs: got %b want 0", {ins_out, ins_valid, addr_err, busy});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({ins_valid, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL abort_quiet cyc%0d: valid/busy=%b want 00", i, {ins_valid, busy});
            end
        end
        do_fetch("abort_post", 8'd2, 2, 8'h33, 1'b0);
    endtask

    task automatic test_collision();
        apply_reset();
        prog_write(8'd0, 8'h11);
        ins_address = 8'd0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        prog_we = 1'b1;
        prog_addr = 8'd0;
        prog_data = 8'h99;
        step();
        prog_we = 1'b0;
        n_cmp++;
        if ({ins_valid, ins_out} !== {1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL coll_old: valid/data=%b/%h want 1/11", ins_valid, ins_out);
        end
        step();
        do_fetch("coll_new", 8'd0, 2, 8'h99, 1'b0);
    endtask

    task automatic test_cache();
        apply_reset();
        do_fetch("cache_cold", 8'd2, 2, 8'h33, 1'b0);
        do_fetch("cache_hit", 8'd2, HitLat, 8'h33, 1'b0);
        prog_write(8'd2, 8'h5A);
        do_fetch("cache_inval", 8'd2, 2, 8'h5A, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gating();
        test_out_of_range();
        test_reset_abort();
        test_collision();
        test_cache();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
